// File: rtl/spi_slave_core_pkg.sv
// Shared definitions for the SPI slave: register map, status bit positions, FSM states.
package spi_slave_core_pkg;

    localparam logic [2:0] ADDR_RXDATA  = 3'd0;
    localparam logic [2:0] ADDR_TXDATA  = 3'd1;
    localparam logic [2:0] ADDR_STATUS  = 3'd2;
    localparam logic [2:0] ADDR_CONTROL = 3'd3;

    localparam int ST_ROE  = 3;
    localparam int ST_TOE  = 4;
    localparam int ST_TUR  = 5;
    localparam int ST_TRDY = 6;
    localparam int ST_RRDY = 7;
    localparam int ST_E    = 8;
    localparam int ST_ABT  = 9;

    // Only the irq-enable positions that line up with status flags are stored.
    localparam logic [15:0] CTRL_MASK = 16'h03F8;

    typedef enum logic {IDLE, ACTIVE} spi_state_e;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [2:0]  addr;
        logic [15:0] wdata;
    } cpu_req_t;

endpackage

// File: rtl/spi_slave_core_sync.sv
// Multi-flop synchronizer plus history flop; rise/fall pulse one cycle per edge.
module spi_slave_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_pipe;
    logic                   hist;
    logic                   sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_pipe <= {SYNC_STAGES{RST_VAL}};
            hist      <= RST_VAL;
        end else begin
            sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], din};
            hist      <= sync_pipe[SYNC_STAGES-1];
        end
    end

    assign sync_q = sync_pipe[SYNC_STAGES-1];
    assign rise   = sync_q & ~hist;
    assign fall   = ~sync_q & hist;

endmodule

// File: rtl/spi_slave_core.sv
// SPI slave endpoint (CPOL=0, CPHA=0, MSB first) with the master's CPU register layout.
module spi_slave_core
    import spi_slave_core_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        SCLK,
    input  logic        SS_n,
    input  logic        MOSI,
    output logic        MISO,
    output logic        MISO_oe,
    input  logic        spi_select,
    input  logic [2:0]  mem_addr,
    input  logic        read_n,
    input  logic        write_n,
    input  logic [15:0] data_from_cpu,
    output logic [15:0] data_to_cpu,
    output logic        irq,
    output logic        dataavailable,
    output logic        readyfordata
);

    logic sclk_rise, sclk_fall, ss_rise, ss_fall;
    logic [SYNC_STAGES-1:0] mosi_pipe;
    logic mosi_s;

    spi_slave_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .clk(clk), .reset(reset), .din(SCLK), .rise(sclk_rise), .fall(sclk_fall)
    );

    // SS_n idles high, so its synchronizer resets high to avoid a phantom edge.
    spi_slave_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
        .clk(clk), .reset(reset), .din(SS_n), .rise(ss_rise), .fall(ss_fall)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) mosi_pipe <= '0;
        else       mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], MOSI};
    end
    assign mosi_s = mosi_pipe[SYNC_STAGES-1];

    logic     rd_strobe, wr_strobe;
    cpu_req_t req;
    logic     rx_rd, tx_wr, st_wr, ctl_wr, tx_accept, tx_reject;

    assign req.rd    = ~rd_strobe & spi_select & ~read_n;
    assign req.wr    = ~wr_strobe & spi_select & ~write_n;
    assign req.addr  = mem_addr;
    assign req.wdata = data_from_cpu;

    spi_state_e state, state_nxt;
    logic [7:0] shift_reg, rx_holding, tx_holding, shifted;
    logic [2:0] bitcnt;
    logic       mosi_bit, primed;
    logic       roe, toe, tur, abt, rrdy;
    logic [15:0] ctrl, status;
    logic       load, sample, shift, byte_done, abort;

    assign rx_rd  = req.rd & (req.addr == ADDR_RXDATA);
    assign tx_wr  = req.wr & (req.addr == ADDR_TXDATA);
    assign st_wr  = req.wr & (req.addr == ADDR_STATUS);
    assign ctl_wr = req.wr & (req.addr == ADDR_CONTROL);
    // A reload frees the holding register in the same cycle it is written.
    assign tx_accept = tx_wr & (~primed | load);
    assign tx_reject = tx_wr & ~tx_accept;
    assign shifted   = {shift_reg[6:0], mosi_bit};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        sample    = 1'b0;
        shift     = 1'b0;
        byte_done = 1'b0;
        abort     = 1'b0;
        MISO_oe   = 1'b0;
        MISO      = 1'b0;
        case (state)
            IDLE: begin
                if (ss_fall) begin
                    load      = 1'b1;
                    state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                MISO_oe = 1'b1;
                MISO    = shift_reg[7];
                if (ss_rise) begin
                    state_nxt = IDLE;
                    abort     = (bitcnt != 3'd0);
                end else begin
                    sample = sclk_rise;
                    if (sclk_fall) begin
                        shift = 1'b1;
                        if (bitcnt == 3'd7) begin
                            byte_done = 1'b1;
                            load      = 1'b1;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_reg  <= '0;
            rx_holding <= '0;
            tx_holding <= '0;
            bitcnt     <= '0;
            mosi_bit   <= 1'b0;
            primed     <= 1'b0;
        end else begin
            if (load)       shift_reg <= primed ? tx_holding : 8'h00;
            else if (shift) shift_reg <= shifted;
            if (load)       bitcnt <= '0;
            else if (shift) bitcnt <= bitcnt + 3'd1;
            if (sample)     mosi_bit <= mosi_s;
            if (byte_done)  rx_holding <= shifted;
            if (tx_accept)  tx_holding <= req.wdata[7:0];
            if (tx_accept)  primed <= 1'b1;
            else if (load)  primed <= 1'b0;
        end
    end

    // Flag sets take priority over the CPU clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            roe  <= 1'b0;
            toe  <= 1'b0;
            tur  <= 1'b0;
            abt  <= 1'b0;
            rrdy <= 1'b0;
            ctrl <= '0;
        end else begin
            rrdy <= byte_done | (rrdy & ~(rx_rd | st_wr));
            roe  <= (byte_done & rrdy & ~rx_rd) | (roe & ~st_wr);
            toe  <= tx_reject | (toe & ~st_wr);
            tur  <= (load & ~primed) | (tur & ~st_wr);
            abt  <= abort | (abt & ~st_wr);
            if (ctl_wr) ctrl <= req.wdata & CTRL_MASK;
        end
    end

    always_comb begin
        status          = '0;
        status[ST_ROE]  = roe;
        status[ST_TOE]  = toe;
        status[ST_TUR]  = tur;
        status[ST_TRDY] = ~primed;
        status[ST_RRDY] = rrdy;
        status[ST_E]    = roe | toe | tur | abt;
        status[ST_ABT]  = abt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_strobe   <= 1'b0;
            wr_strobe   <= 1'b0;
            data_to_cpu <= '0;
            irq         <= 1'b0;
        end else begin
            rd_strobe <= req.rd;
            wr_strobe <= req.wr;
            irq       <= |(status & ctrl);
            if (req.rd) begin
                case (req.addr)
                    ADDR_RXDATA:  data_to_cpu <= {8'h00, rx_holding};
                    ADDR_STATUS:  data_to_cpu <= status;
                    ADDR_CONTROL: data_to_cpu <= ctrl;
                    default:      data_to_cpu <= '0;
                endcase
            end
        end
    end

    assign dataavailable = rrdy;
    assign readyfordata  = ~primed;

endmodule

// File: tb/tb_spi_slave_core.sv
// Directed and randomized bench for spi_slave_core acting against a behavioural SPI master model.
module tb_spi_slave_core;

    logic        clk = 1'b0;
    logic        reset, SCLK, SS_n, MOSI;
    logic        MISO, MISO_oe;
    logic        spi_select, read_n, write_n;
    logic [2:0]  mem_addr;
    logic [15:0] data_from_cpu, data_to_cpu;
    logic        irq, dataavailable, readyfordata;

    int errors = 0;
    int checks = 0;
    int half   = 8;

    spi_slave_core #(.SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .SCLK(SCLK), .SS_n(SS_n), .MOSI(MOSI),
        .MISO(MISO), .MISO_oe(MISO_oe), .spi_select(spi_select), .mem_addr(mem_addr),
        .read_n(read_n), .write_n(write_n), .data_from_cpu(data_from_cpu),
        .data_to_cpu(data_to_cpu), .irq(irq), .dataavailable(dataavailable),
        .readyfordata(readyfordata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cpu_write(input logic [2:0] a, input logic [15:0] d);
        spi_select = 1'b1; mem_addr = a; data_from_cpu = d; write_n = 1'b0;
        tick(); tick();
        spi_select = 1'b0; write_n = 1'b1;
        tick();
    endtask

    task automatic cpu_read(input logic [2:0] a, output logic [15:0] d);
        spi_select = 1'b1; mem_addr = a; read_n = 1'b0;
        tick(); tick();
        spi_select = 1'b0; read_n = 1'b1;
        tick();
        d = data_to_cpu;
    endtask

    task automatic ss_low();
        SS_n = 1'b0;
        repeat (half) tick();
    endtask

    task automatic ss_high();
        repeat (half) tick();
        SS_n = 1'b1;
        repeat (half) tick();
    endtask

    // Master side: drive MOSI before the rising edge, capture MISO just before it.
    task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] got);
        got = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            MOSI = tx[7-i];
            repeat (half) tick();
            got = {got[6:0], MISO};
            SCLK = 1'b1;
            repeat (half) tick();
            SCLK = 1'b0;
        end
    endtask

    function automatic logic [15:0] mk_status(input logic roe, toe, tur, trdy, rrdy, abt);
        logic [15:0] s;
        s = 16'h0000;
        s[3] = roe; s[4] = toe; s[5] = tur; s[6] = trdy; s[7] = rrdy;
        s[8] = roe | toe | tur | abt; s[9] = abt;
        return s;
    endfunction

    initial begin
        logic [15:0] rd;
        logic [7:0]  got, tx, rx, m_rx;
        logic        m_rrdy, m_roe, m_tur, wr;

        reset = 1'b1; SCLK = 1'b0; SS_n = 1'b1; MOSI = 1'b0;
        spi_select = 1'b0; read_n = 1'b1; write_n = 1'b1;
        mem_addr = 3'd0; data_from_cpu = 16'h0000;
        repeat (3) tick();
        chk("rst_miso_oe", {15'd0, MISO_oe}, 16'h0);
        chk("rst_trdy", {15'd0, readyfordata}, 16'h1);
        chk("rst_rrdy", {15'd0, dataavailable}, 16'h0);
        reset = 1'b0;
        repeat (3) tick();
        cpu_read(3'd2, rd);
        chk("rst_status", rd, 16'h0040);

        // Single byte, tx 0xA5 / rx 0x3C
        cpu_write(3'd1, 16'h00A5);
        chk("t1_trdy_primed", {15'd0, readyfordata}, 16'h0);
        ss_low();
        chk("t1_trdy_after_ss", {15'd0, readyfordata}, 16'h1);
        chk("t1_miso_oe", {15'd0, MISO_oe}, 16'h1);
        spi_xfer(8'h3C, 8, got);
        ss_high();
        chk("t1_miso_byte", {8'h00, got}, 16'h00A5);
        chk("t1_rrdy", {15'd0, dataavailable}, 16'h1);
        cpu_read(3'd0, rd);
        chk("t1_rxdata", rd, 16'h003C);
        chk("t1_rrdy_clr", {15'd0, dataavailable}, 16'h0);

        // Two bytes under one held SS_n
        cpu_write(3'd2, 16'h0000);
        cpu_write(3'd1, 16'h0011);
        ss_low();
        cpu_write(3'd1, 16'h0022);
        spi_xfer(8'h81, 8, got);
        chk("t2_miso_b1", {8'h00, got}, 16'h0011);
        fork
            spi_xfer(8'h42, 8, tx);
            begin
                repeat (20) tick();
                cpu_read(3'd0, rd);
                chk("t2_rx_b1", rd, 16'h0081);
            end
        join
        ss_high();
        chk("t2_miso_b2", {8'h00, tx}, 16'h0022);
        cpu_read(3'd0, rd);
        chk("t2_rx_b2", rd, 16'h0042);
        cpu_read(3'd2, rd);
        chk("t2_no_roe", rd & 16'h0008, 16'h0000);

        // Overrun with irq on ROE
        cpu_write(3'd2, 16'hFFFF);
        cpu_write(3'd3, 16'h0008);
        ss_low(); spi_xfer(8'h5C, 8, got); ss_high();
        chk("t3_irq_low", {15'd0, irq}, 16'h0);
        ss_low(); spi_xfer(8'hC5, 8, got); ss_high();
        chk("t3_irq_high", {15'd0, irq}, 16'h1);
        cpu_read(3'd2, rd);
        chk("t3_roe", rd & 16'h0008, 16'h0008);
        cpu_read(3'd0, rd);
        chk("t3_rx_second", rd, 16'h00C5);
        cpu_write(3'd2, 16'h0000);
        chk("t3_irq_fall", {15'd0, irq}, 16'h0);
        cpu_read(3'd2, rd);
        chk("t3_roe_clr", rd & 16'h0008, 16'h0000);
        cpu_write(3'd3, 16'h0000);

        // Underrun, then tx overwrite
        cpu_write(3'd2, 16'h0000);
        ss_low(); spi_xfer(8'h99, 8, got); ss_high();
        chk("t4_miso_zero", {8'h00, got}, 16'h0000);
        cpu_read(3'd2, rd);
        chk("t4_tur_e", rd & 16'h0120, 16'h0120);
        cpu_write(3'd1, 16'h003A);
        cpu_write(3'd1, 16'h007E);
        cpu_read(3'd2, rd);
        chk("t4_toe", rd & 16'h0010, 16'h0010);
        ss_low(); spi_xfer(8'h24, 8, got); ss_high();
        chk("t4_tx_kept", {8'h00, got}, 16'h003A);

        // Abort after 3 bits with RRDY already set
        cpu_write(3'd2, 16'h0000);
        cpu_read(3'd0, rd);
        ss_low(); spi_xfer(8'hE7, 8, got); ss_high();
        ss_low(); spi_xfer(8'hFF, 3, got); ss_high();
        cpu_read(3'd2, rd);
        chk("t5_abt", rd & 16'h0200, 16'h0200);
        chk("t5_rrdy_kept", rd & 16'h0080, 16'h0080);
        cpu_read(3'd0, rd);
        chk("t5_rx_kept", rd, 16'h00E7);
        cpu_write(3'd1, 16'h005A);
        ss_low(); spi_xfer(8'hF0, 8, got); ss_high();
        chk("t5_miso_realign", {8'h00, got}, 16'h005A);
        cpu_read(3'd0, rd);
        chk("t5_rx_realign", rd, 16'h00F0);

        // Randomized bytes against a flag-level model
        cpu_write(3'd2, 16'h0000);
        cpu_read(3'd0, rd);
        m_rrdy = 1'b0; m_roe = 1'b0; m_tur = 1'b0; m_rx = 8'h00;
        for (int it = 0; it < 12; it++) begin
            wr   = 1'($urandom % 2);
            tx   = 8'($urandom);
            rx   = 8'($urandom);
            half = int'($urandom_range(6, 10));
            if ($urandom % 4 == 0) begin
                cpu_write(3'd2, 16'($urandom));
                m_rrdy = 1'b0; m_roe = 1'b0; m_tur = 1'b0;
            end
            if (wr) cpu_write(3'd1, {8'h00, tx});
            ss_low(); spi_xfer(rx, 8, got); ss_high();
            chk("rnd_miso", {8'h00, got}, {8'h00, wr ? tx : 8'h00});
            // Nothing is queued behind the byte, so its completion reload underruns.
            m_roe  = m_roe | m_rrdy;
            m_rrdy = 1'b1;
            m_rx   = rx;
            m_tur  = 1'b1;
            if ($urandom % 2 == 1) begin
                cpu_read(3'd0, rd);
                chk("rnd_rx", rd, {8'h00, m_rx});
                m_rrdy = 1'b0;
            end
            cpu_read(3'd2, rd);
            chk("rnd_status", rd, mk_status(m_roe, 1'b0, m_tur, 1'b1, m_rrdy, 1'b0));
        end
        half = 8;

        // Reset mid-byte
        cpu_write(3'd1, 16'h0077);
        ss_low(); spi_xfer(8'hAB, 5, got);
        chk("t6_oe_before", {15'd0, MISO_oe}, 16'h1);
        reset = 1'b1; SS_n = 1'b1; SCLK = 1'b0;
        #1;
        chk("t6_oe_async", {15'd0, MISO_oe}, 16'h0);
        chk("t6_miso", {15'd0, MISO}, 16'h0);
        chk("t6_data_to_cpu", data_to_cpu, 16'h0000);
        repeat (3) tick();
        reset = 1'b0;
        repeat (3) tick();
        chk("t6_irq", {15'd0, irq}, 16'h0);
        cpu_read(3'd2, rd);
        chk("t6_status", rd, 16'h0040);
        cpu_read(3'd0, rd);
        chk("t6_rxdata", rd, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
